// File: rtl/sonic_st_pkg.sv
// Shared constants and elaboration helpers for the sonic streaming blocks.
// Holds the depth legality rule, drop counter width and clog2.
package sonic_st_pkg;

    localparam int DROP_CNT_W = 16;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                r++;
                v = v >> 1;
            end
        end
        return r;
    endfunction

    function automatic bit depth_legal(input int depth);
        return (depth >= 2) && (depth <= 64) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/sonic_st_sc_fifo_mem.sv
// Single-clock storage array: one synchronous write port, one async read port.
// Contents are deliberately not reset.
module sonic_st_sc_fifo_mem #(
    parameter int WIDTH  = 9,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sonic_st_timing_adapter_fifo.sv
// Show-ahead timing adapter FIFO with one cycle of latency, drop accounting
// and a sticky overflow flag for upstreams that cannot be backpressured.
module sonic_st_timing_adapter_fifo
    import sonic_st_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CHANNEL_W    = 1,
    parameter int DEPTH        = 4,
    parameter int USE_IN_READY = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    input  logic [CHANNEL_W-1:0]         in_channel,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    output logic [CHANNEL_W-1:0]         out_channel,
    input  logic                         out_ready,
    output logic [clog2(DEPTH+1)-1:0]    fill_level,
    output logic                         overflow,
    output logic [DROP_CNT_W-1:0]        drop_count,
    input  logic                         clr_overflow
);

    localparam int PTR_W  = clog2(DEPTH);
    localparam int FILL_W = clog2(DEPTH + 1);
    localparam int MEM_W  = DATA_W + CHANNEL_W;

    if (!depth_legal(DEPTH)) begin : g_bad_depth
        $fatal(1, "sonic_st_timing_adapter_fifo: DEPTH must be a power of two in 2..64");
    end

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0]     count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic                  full, push, pop, drop;
    logic [MEM_W-1:0]      rd_word;

    // Everything visible upstream comes from flops only.
    assign full      = (count_q == FILL_W'(DEPTH));
    assign in_ready  = !full;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign push      = in_valid && (!full || pop);
    assign drop      = in_valid && full && !pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q + FILL_W'(push) - FILL_W'(pop);
        overflow_d = clr_overflow ? 1'b0 : overflow_q;
        drop_cnt_d = clr_overflow ? '0 : drop_cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // A drop in the clear cycle wins over the clear.
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_d != '1) begin
                drop_cnt_d = drop_cnt_d + DROP_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    sonic_st_sc_fifo_mem #(
        .WIDTH  (MEM_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push && !reset),
        .waddr (wr_ptr_q),
        .wdata ({in_channel, in_data}),
        .raddr (rd_ptr_q),
        .rdata (rd_word)
    );

    assign {out_channel, out_data} = rd_word;
    assign fill_level = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_cnt_q;

    if (USE_IN_READY != 0) begin : g_proto_chk
        always @(posedge clk) begin
            assert (reset || !in_valid || in_ready)
            else $error("sonic_st_timing_adapter_fifo: beat presented while in_ready=0");
        end
    end

endmodule

// File: tb/tb_sonic_st_timing_adapter_fifo.sv
// Bench for the timing adapter FIFO: directed DEPTH=4 scenarios plus a
// randomized DEPTH=8 run against a queue model.
module tb_sonic_st_timing_adapter_fifo;

    logic clk;

    // DEPTH=4, no backpressure
    logic        a_reset, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0]  a_in_data, a_out_data;
    logic [0:0]  a_in_channel, a_out_channel;
    logic [2:0]  a_fill;
    logic        a_overflow, a_clr;
    logic [15:0] a_drop;

    // DEPTH=8, upstream honours in_ready
    logic        b_reset, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [15:0] b_in_data, b_out_data;
    logic [2:0]  b_in_channel, b_out_channel;
    logic [3:0]  b_fill;
    logic        b_overflow, b_clr;
    logic [15:0] b_drop;

    int n_cmp = 0;
    int n_err = 0;

    sonic_st_timing_adapter_fifo #(
        .DATA_W(8), .CHANNEL_W(1), .DEPTH(4), .USE_IN_READY(0)
    ) dut_a (
        .clk(clk), .reset(a_reset),
        .in_valid(a_in_valid), .in_data(a_in_data), .in_channel(a_in_channel),
        .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_channel(a_out_channel),
        .out_ready(a_out_ready),
        .fill_level(a_fill), .overflow(a_overflow), .drop_count(a_drop),
        .clr_overflow(a_clr)
    );

    sonic_st_timing_adapter_fifo #(
        .DATA_W(16), .CHANNEL_W(3), .DEPTH(8), .USE_IN_READY(1)
    ) dut_b (
        .clk(clk), .reset(b_reset),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_channel(b_in_channel),
        .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_channel(b_out_channel),
        .out_ready(b_out_ready),
        .fill_level(b_fill), .overflow(b_overflow), .drop_count(b_drop),
        .clr_overflow(b_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs set before tick are sampled at the edge; checks after tick see post-edge state.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_beat(input logic [7:0] d);
        a_in_valid   = 1'b1;
        a_in_data    = d;
        a_in_channel = d[0];
    endtask

    initial begin
        logic [18:0] q[$];
        logic [18:0] expw;
        logic [8:0]  qa[$];
        logic [8:0]  ea;
        int sent;
        int cyc;
        bit full_m;
        bit pop_m;

        a_reset = 1'b1; a_in_valid = 1'b0; a_in_data = '0; a_in_channel = '0;
        a_out_ready = 1'b0; a_clr = 1'b0;
        b_reset = 1'b1; b_in_valid = 1'b0; b_in_data = '0; b_in_channel = '0;
        b_out_ready = 1'b0; b_clr = 1'b0;
        tick();
        tick();

        chk("rst_fill", a_fill, 0);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_overflow", a_overflow, 0);
        chk("rst_drop", a_drop, 0);

        // Streaming with out_ready=1: one cycle latency, occupancy at most 1
        a_reset = 1'b0;
        a_out_ready = 1'b1;
        a_beat(8'h11);
        tick();
        chk("s_valid0", a_out_valid, 1);
        chk("s_data0", {a_out_channel, a_out_data}, {1'b1, 8'h11});
        chk("s_fill0", a_fill, 1);
        a_beat(8'h22);
        tick();
        chk("s_data1", {a_out_channel, a_out_data}, {1'b0, 8'h22});
        chk("s_fill1", a_fill, 1);
        a_beat(8'h33);
        tick();
        chk("s_data2", {a_out_channel, a_out_data}, {1'b1, 8'h33});
        chk("s_fill2", a_fill, 1);
        a_in_valid = 1'b0;
        tick();
        chk("s_drained", a_out_valid, 0);
        chk("s_fill3", a_fill, 0);

        // Overfill with out_ready=0: 6 beats, 2 dropped
        a_out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a_beat(8'hA1 + 8'(i));
            tick();
            if (i == 3) begin
                chk("of_full_fill", a_fill, 4);
                chk("of_no_drop_yet", a_drop, 0);
                chk("of_no_ovf_yet", a_overflow, 0);
            end
            chk("of_head_stable", a_out_data, 8'hA1);
        end
        a_in_valid = 1'b0;
        chk("of_fill", a_fill, 4);
        chk("of_in_ready", a_in_ready, 0);
        chk("of_overflow", a_overflow, 1);
        chk("of_drop", a_drop, 2);
        a_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("of_drain_valid", a_out_valid, 1);
            chk("of_drain_data", a_out_data, 8'hA1 + 8'(i));
            tick();
        end
        chk("of_empty", a_out_valid, 0);
        chk("of_ovf_sticky", a_overflow, 1);

        // Plain clear
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        chk("clr_overflow", a_overflow, 0);
        chk("clr_drop", a_drop, 0);

        // Full with simultaneous push and pop for 10 cycles
        a_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_beat(8'(8'h40 + 8'(i)));
            qa.push_back({a_in_channel, a_in_data});
            tick();
        end
        a_out_ready = 1'b1;
        for (int i = 4; i < 14; i++) begin
            a_beat(8'(8'h40 + 8'(i)));
            ea = qa.pop_front();
            chk("fp_head", {a_out_channel, a_out_data}, ea);
            qa.push_back({a_in_channel, a_in_data});
            tick();
            chk("fp_fill", a_fill, 4);
            chk("fp_drop", a_drop, 0);
        end

        // Drop in the same cycle as clear
        a_out_ready = 1'b0;
        a_beat(8'hEE);
        tick();
        tick();
        chk("dc_pre_drop", a_drop, 2);
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        a_in_valid = 1'b0;
        chk("dc_overflow", a_overflow, 1);
        chk("dc_drop", a_drop, 1);
        chk("dc_head_kept", {a_out_channel, a_out_data}, qa[0]);

        // Reset mid-stream with 3 beats buffered; in_valid ignored during reset
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        chk("mr_fill3", a_fill, 3);
        a_reset = 1'b1;
        a_beat(8'h99);
        tick();
        chk("mr_valid", a_out_valid, 0);
        chk("mr_fill", a_fill, 0);
        chk("mr_drop", a_drop, 0);
        a_reset = 1'b0;
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mr_no_stale", a_out_valid, 0);
        end

        // Randomized run on DEPTH=8 with an obedient upstream
        b_reset = 1'b0;
        tick();
        chk("b_rst_in_ready", b_in_ready, 1);
        sent = 0;
        cyc = 0;
        while (sent < 1000 && cyc < 20000) begin
            cyc++;
            b_out_ready  = ($urandom_range(0, 2) != 0);
            b_in_valid   = ($urandom_range(0, 3) != 0) && b_in_ready;
            b_in_data    = 16'($urandom);
            b_in_channel = 3'($urandom);
            chk("b_fill", b_fill, q.size());
            chk("b_in_ready", b_in_ready, q.size() < 8);
            chk("b_out_valid", b_out_valid, q.size() != 0);
            full_m = (q.size() == 8);
            pop_m  = (q.size() != 0) && b_out_ready;
            if (pop_m) begin
                expw = q.pop_front();
                chk("b_head", {b_out_channel, b_out_data}, expw);
            end
            if (b_in_valid && (!full_m || pop_m)) begin
                q.push_back({b_in_channel, b_in_data});
                sent++;
            end
            tick();
        end
        chk("b_sent_all", sent, 1000);
        b_in_valid = 1'b0;
        b_out_ready = 1'b1;
        cyc = 0;
        while (q.size() != 0 && cyc < 50) begin
            cyc++;
            chk("b_drain_valid", b_out_valid, 1);
            expw = q.pop_front();
            chk("b_drain_head", {b_out_channel, b_out_data}, expw);
            tick();
        end
        chk("b_model_empty", q.size(), 0);
        chk("b_final_valid", b_out_valid, 0);
        chk("b_final_drop", b_drop, 0);
        chk("b_final_overflow", b_overflow, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sonic_st_timing_adapter_fifo.md
SONIC_ST_TIMING_ADAPTER_FIFO -- requirements
Module: sonic_st_timing_adapter_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning payload width in bits (1..512).
REQ-002 SHALL have parameter CHANNEL_W, default 1, meaning channel sideband width (1..8), carried alongside data.
REQ-003 SHALL have parameter DEPTH, default 4, meaning buffer entries; power of two, 2..64.
REQ-004 SHALL have parameter USE_IN_READY, default 0, meaning 1 = upstream honours in_ready, 0 = upstream cannot be backpressured.
REQ-005 SHALL have port clk, input, 1, meaning the single clock.
REQ-006 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-007 SHALL have ports in_valid (input, 1), in_data (input, DATA_W) and in_channel (input, CHANNEL_W), forming the upstream beat.
REQ-008 SHALL have port in_ready, output, 1, meaning !full; it is driven even when USE_IN_READY=0.
REQ-009 SHALL have ports out_valid (output, 1), out_data (output, DATA_W) and out_channel (output, CHANNEL_W), forming the downstream beat.
REQ-010 SHALL have port out_ready, input, 1, meaning downstream ready at ready latency 0.
REQ-011 SHALL have port fill_level, output, clog2(DEPTH+1), meaning entries currently held.
REQ-012 SHALL have port overflow, output, 1, meaning a sticky beat-dropped flag.
REQ-013 SHALL have port drop_count, output, 16, meaning the number of dropped beats, saturating at 0xFFFF.
REQ-014 SHALL have port clr_overflow, input, 1, meaning a one-cycle clear of overflow and drop_count.

Function
REQ-015 SHALL define push = in_valid && (!full || pop) and pop = out_valid && out_ready, where full = (fill_level==DEPTH).
REQ-016 SHALL be show-ahead: out_valid = (fill_level!=0); out_data and out_channel always equal the head entry.
REQ-017 SHALL have a latency of exactly 1 cycle: a beat pushed at edge N is visible on out_* after edge N; there is no combinational in->out bypass.
REQ-018 SHALL derive in_ready from registered state only; there is no combinational path from out_ready to in_ready.
REQ-019 SHALL permit a simultaneous push and pop when full; fill_level stays DEPTH and ordering is preserved.
REQ-020 SHALL treat push and pop in the same cycle when empty as a push only; the beat appears next cycle (there is no fall-through).
REQ-021 SHALL drop a beat presented with in_valid=1, full=1 and pop=0, so that storage, pointers and fill_level are unchanged.
REQ-022 SHALL set overflow on every drop and increment drop_count, saturating at 0xFFFF.
REQ-023 SHALL, when USE_IN_READY=1, additionally flag a beat presented with in_ready=0 as a protocol error under simulation only; the RTL action is identical to REQ-021.
REQ-024 SHALL, on clr_overflow=1, clear overflow to 0 and drop_count to 0; if a drop occurs in the same cycle, overflow becomes 1 and drop_count 1.
REQ-025 SHALL use log2(DEPTH)-bit read and write pointers that wrap modulo DEPTH; fill_level is tracked by a separate counter.
REQ-026 SHALL keep out_data and out_channel stable while out_valid=1 and out_ready=0.
REQ-027 SHALL not change behaviour while in_valid=0, apart from draining.

Reset
REQ-028 SHALL, while reset=1 at a clk edge, clear the pointers, set fill_level=0, out_valid=0, in_ready=1, overflow=0 and drop_count=0.
REQ-029 SHALL discard buffered beats on reset asserted mid-stream; none are emitted afterwards.
REQ-030 SHALL leave storage RAM contents unreset; out_data is don't-care while out_valid=0.
REQ-031 SHALL ignore in_valid during the reset cycle.

Structure
REQ-032 SHALL place the DEPTH legality check, the drop_count width constant (16) and the clog2 helper in the shared package sonic_st_pkg.
REQ-033 SHALL contain a single sub-module, sonic_st_sc_fifo_mem, holding the DEPTH x (DATA_W+CHANNEL_W) storage with one write port and one async read port; the control logic stays in the top module.
REQ-034 SHALL reject an illegal DEPTH at elaboration.

Verification
REQ-035 SHALL cover reset release with out_ready=1: pushing 0x11,0x22,0x33 on consecutive cycles gives out_data 0x11,0x22,0x33 one cycle later each, with fill_level never above 1.
REQ-036 SHALL cover DEPTH=4 with out_ready=0: pushing 6 beats gives fill_level=4, in_ready=0, overflow=1 and drop_count=2; releasing out_ready then yields beats 1-4 in order.
REQ-037 SHALL cover the full case with simultaneous push and pop over 10 cycles: fill_level stays 4, drop_count stays 0, and the order is intact.
REQ-038 SHALL cover clr_overflow in the same cycle as a drop: overflow=1 and drop_count=1.
REQ-039 SHALL cover reset asserted with 3 beats buffered: next cycle out_valid=0 and fill_level=0, and no stale beat appears after reset.
REQ-040 SHALL cover pointer wrap: 1000 random beats with random out_ready and DEPTH=8, checked by a scoreboard for zero loss when USE_IN_READY=1 and the upstream obeys in_ready.
